// File: rtl/train_crossing_sequencer.sv
// -----------------------------------------------------------------------------
// train_crossing_sequencer
//
// Level-crossing controller. Tracks how many trains sit between the approach
// and clear sensors of two tracks, and sequences lights, bell and gate motor
// through warning, lowering, closed, hold and raising phases. A gate that
// fails to reach its limit switch in time drops the sequencer into FAULT,
// where the gate is driven down until an operator acknowledges.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   synchronous, active-high reset
//   approach_a/b   in   one-cycle arrival pulses, track A/B
//   clear_a/b      in   one-cycle departure pulses, track A/B
//   gate_down_lim  in   gate fully-down limit switch (level)
//   gate_up_lim    in   gate fully-up limit switch (level)
//   fault_clr      in   operator fault acknowledge
//   lights         out  flashing-light enable
//   bell           out  bell enable
//   gate_cmd_down  out  motor command, lower
//   gate_cmd_up    out  motor command, raise
//   fault          out  sequencer is in FAULT
//   occ            out  registered train occupancy count (OCC_W bits)
// -----------------------------------------------------------------------------
module train_crossing_sequencer #(
   parameter int WARN_CYCLES    = 8,
   parameter int MOTION_TIMEOUT = 16,
   parameter int HOLD_CYCLES    = 4,
   parameter int OCC_W          = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             approach_a,
   input  logic             approach_b,
   input  logic             clear_a,
   input  logic             clear_b,
   input  logic             gate_down_lim,
   input  logic             gate_up_lim,
   input  logic             fault_clr,
   output logic             lights,
   output logic             bell,
   output logic             gate_cmd_down,
   output logic             gate_cmd_up,
   output logic             fault,
   output logic [OCC_W-1:0] occ
);

   // Timer holds (duration - 1) on entry and counts down to zero; the state
   // leaves on the cycle the timer reads zero, so a load of N-1 gives exactly
   // N cycles in state.
   localparam int T_MAX_WH = (WARN_CYCLES > HOLD_CYCLES) ? WARN_CYCLES : HOLD_CYCLES;
   localparam int T_MAX    = (T_MAX_WH > MOTION_TIMEOUT) ? T_MAX_WH : MOTION_TIMEOUT;
   localparam int TMR_W    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [TMR_W-1:0] WARN_LOAD   = TMR_W'(WARN_CYCLES - 1);
   localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] MOTION_LOAD = TMR_W'(MOTION_TIMEOUT - 1);

   localparam logic signed [OCC_W+2:0] OCC_MAX_S = (OCC_W+3)'((1 << OCC_W) - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WARN     = 3'd1,
      S_LOWERING = 3'd2,
      S_CLOSED   = 3'd3,
      S_HOLD     = 3'd4,
      S_RAISING  = 3'd5,
      S_FAULT    = 3'd6
   } state_t;

   state_t           state, state_nxt;
   logic [TMR_W-1:0] tmr, tmr_nxt;
   logic [OCC_W-1:0] occ_nxt;
   logic [1:0]       arrivals, departures;
   logic             tmr_done;

   // Net occupancy update, saturated to [0, 2^OCC_W-1]. Worked in a signed
   // word three bits wider so the +2/-2 swing can never wrap.
   function automatic logic [OCC_W-1:0] sat_occ(
      input logic [OCC_W-1:0] cur,
      input logic [1:0]       arr,
      input logic [1:0]       dep
   );
      logic signed [OCC_W+2:0] sum;
      sum = $signed({3'b000, cur})
          + $signed({{(OCC_W+1){1'b0}}, arr})
          - $signed({{(OCC_W+1){1'b0}}, dep});
      if (sum[OCC_W+2]) begin
         sat_occ = '0;
      end else if (sum > OCC_MAX_S) begin
         sat_occ = '1;
      end else begin
         sat_occ = sum[OCC_W-1:0];
      end
   endfunction

   assign arrivals   = {1'b0, approach_a} + {1'b0, approach_b};
   assign departures = {1'b0, clear_a} + {1'b0, clear_b};
   assign occ_nxt    = sat_occ(occ, arrivals, departures);
   assign tmr_done   = (tmr == '0);

   // State, timer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         tmr   <= '0;
         occ   <= '0;
      end else begin
         state <= state_nxt;
         tmr   <= tmr_nxt;
         occ   <= occ_nxt;
      end
   end

   // Next-state and timer-load logic. Every occupancy decision looks at
   // occ_nxt so a train arriving this cycle is acted on immediately.
   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr_done ? tmr : (tmr - TMR_W'(1));
      unique case (state)
         S_IDLE: begin
            if (occ_nxt != '0) begin
               state_nxt = S_WARN;
               tmr_nxt   = WARN_LOAD;
            end
         end
         S_WARN: begin
            // Warning always runs to completion, even if the train clears.
            if (tmr_done) begin
               state_nxt = S_LOWERING;
               tmr_nxt   = MOTION_LOAD;
            end
         end
         S_LOWERING: begin
            // Limit switch is checked first so it wins on the final cycle.
            if (gate_down_lim) begin
               state_nxt = S_CLOSED;
               tmr_nxt   = '0;
            end else if (tmr_done) begin
               state_nxt = S_FAULT;
               tmr_nxt   = '0;
            end
         end
         S_CLOSED: begin
            if (occ_nxt == '0) begin
               state_nxt = S_HOLD;
               tmr_nxt   = HOLD_LOAD;
            end
         end
         S_HOLD: begin
            if (occ_nxt != '0) begin
               state_nxt = S_CLOSED;
               tmr_nxt   = '0;
            end else if (tmr_done) begin
               state_nxt = S_RAISING;
               tmr_nxt   = MOTION_LOAD;
            end
         end
         S_RAISING: begin
            // A new train reverses the gate before any limit is honoured.
            if (occ_nxt != '0) begin
               state_nxt = S_LOWERING;
               tmr_nxt   = MOTION_LOAD;
            end else if (gate_up_lim) begin
               state_nxt = S_IDLE;
               tmr_nxt   = '0;
            end else if (tmr_done) begin
               state_nxt = S_FAULT;
               tmr_nxt   = '0;
            end
         end
         S_FAULT: begin
            // Acknowledge only takes effect once the crossing is empty.
            if (fault_clr && (occ_nxt == '0)) begin
               state_nxt = S_RAISING;
               tmr_nxt   = MOTION_LOAD;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            tmr_nxt   = '0;
         end
      endcase
   end

   // Moore output decode. Down and up commands come from disjoint states,
   // so they can never be asserted together.
   always_comb begin
      lights        = 1'b0;
      bell          = 1'b0;
      gate_cmd_down = 1'b0;
      gate_cmd_up   = 1'b0;
      fault         = 1'b0;
      unique case (state)
         S_IDLE: begin
         end
         S_WARN: begin
            lights = 1'b1;
            bell   = 1'b1;
         end
         S_LOWERING: begin
            lights        = 1'b1;
            bell          = 1'b1;
            gate_cmd_down = 1'b1;
         end
         S_CLOSED, S_HOLD: begin
            lights = 1'b1;
         end
         S_RAISING: begin
            lights      = 1'b1;
            gate_cmd_up = 1'b1;
         end
         S_FAULT: begin
            lights        = 1'b1;
            bell          = 1'b1;
            gate_cmd_down = 1'b1;
            fault         = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_train_crossing_sequencer.sv
// -----------------------------------------------------------------------------
// tb_train_crossing_sequencer
//
// Directed, table-driven bench for train_crossing_sequencer at default
// parameters. Each record gives the inputs held for one clock cycle and the
// occupancy and outputs expected just after that edge.
// Output vector order: {lights, bell, gate_cmd_down, gate_cmd_up, fault}.
// Input vector order:  {rst, approach_a, approach_b, clear_a, clear_b,
//                       gate_down_lim, gate_up_lim, fault_clr}.
// -----------------------------------------------------------------------------
module tb_train_crossing_sequencer;

   localparam logic [7:0] I_NONE = 8'h00;
   localparam logic [7:0] I_RST  = 8'h80;
   localparam logic [7:0] I_AA   = 8'h40;
   localparam logic [7:0] I_AB   = 8'h20;
   localparam logic [7:0] I_CA   = 8'h10;
   localparam logic [7:0] I_CB   = 8'h08;
   localparam logic [7:0] I_DL   = 8'h04;
   localparam logic [7:0] I_UL   = 8'h02;
   localparam logic [7:0] I_FC   = 8'h01;

   localparam logic [4:0] O_IDLE = 5'b00000;
   localparam logic [4:0] O_WARN = 5'b11000;
   localparam logic [4:0] O_LOW  = 5'b11100;
   localparam logic [4:0] O_CLS  = 5'b10000;
   localparam logic [4:0] O_HOLD = 5'b10000;
   localparam logic [4:0] O_RAIS = 5'b10010;
   localparam logic [4:0] O_FLT  = 5'b11101;

   typedef struct {
      string      name;
      logic [7:0] in;
      logic [2:0] occ;
      logic [4:0] outs;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst, approach_a, approach_b, clear_a, clear_b;
   logic       gate_down_lim, gate_up_lim, fault_clr;
   logic       lights, bell, gate_cmd_down, gate_cmd_up, fault;
   logic [2:0] occ;

   int errors = 0;
   int checks = 0;
   vec_t tbl[$];

   train_crossing_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .approach_a    (approach_a),
      .approach_b    (approach_b),
      .clear_a       (clear_a),
      .clear_b       (clear_b),
      .gate_down_lim (gate_down_lim),
      .gate_up_lim   (gate_up_lim),
      .fault_clr     (fault_clr),
      .lights        (lights),
      .bell          (bell),
      .gate_cmd_down (gate_cmd_down),
      .gate_cmd_up   (gate_cmd_up),
      .fault         (fault),
      .occ           (occ)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, summary not reached");
      $fatal(1, "watchdog expired");
   end

   task automatic add(input int n, input string name, input logic [7:0] in,
                      input logic [2:0] e_occ, input logic [4:0] e_outs);
      vec_t v;
      v.name = name;
      v.in   = in;
      v.occ  = e_occ;
      v.outs = e_outs;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   task automatic apply(input vec_t v);
      logic [4:0] got;
      {rst, approach_a, approach_b, clear_a, clear_b,
       gate_down_lim, gate_up_lim, fault_clr} = v.in;
      @(posedge clk);
      #1;
      got = {lights, bell, gate_cmd_down, gate_cmd_up, fault};
      checks++;
      if (occ !== v.occ) begin
         errors++;
         $display("FAIL %s occ: got %0d expected %0d", v.name, occ, v.occ);
      end
      checks++;
      if (got !== v.outs) begin
         errors++;
         $display("FAIL %s outputs{l,b,dn,up,f}: got %b expected %b", v.name, got, v.outs);
      end
      checks++;
      if (gate_cmd_down && gate_cmd_up) begin
         errors++;
         $display("FAIL %s motor_exclusive: got dn=%b up=%b expected not both 1",
                  v.name, gate_cmd_down, gate_cmd_up);
      end
   endtask

   task automatic step(input int n, input string name, input logic [7:0] in,
                       input logic [2:0] e_occ, input logic [4:0] e_outs);
      vec_t v;
      v.name = name;
      v.in   = in;
      v.occ  = e_occ;
      v.outs = e_outs;
      for (int i = 0; i < n; i++) apply(v);
   endtask

   initial begin
      {rst, approach_a, approach_b, clear_a, clear_b,
       gate_down_lim, gate_up_lim, fault_clr} = I_RST;

      // Main crossing cycle, occupancy arithmetic and limit handling.
      add(2, "reset",        I_RST,         3'd0, O_IDLE);
      add(1, "arrive_a",     I_AA,          3'd1, O_WARN);
      add(7, "warn",         I_NONE,        3'd1, O_WARN);
      add(1, "lower_start",  I_NONE,        3'd1, O_LOW);
      add(3, "lowering",     I_NONE,        3'd1, O_LOW);
      add(1, "down_lim",     I_DL,          3'd1, O_CLS);
      add(1, "closed",       I_NONE,        3'd1, O_CLS);
      add(1, "clear_a",      I_CA,          3'd0, O_HOLD);
      add(3, "hold",         I_NONE,        3'd0, O_HOLD);
      add(1, "raise",        I_NONE,        3'd0, O_RAIS);
      add(1, "up_lim",       I_UL,          3'd0, O_IDLE);
      add(1, "idle_net0",    I_AA | I_CA,   3'd0, O_IDLE);
      add(1, "arrive_b",     I_AB,          3'd1, O_WARN);
      add(7, "warn2",        I_NONE,        3'd1, O_WARN);
      add(1, "lower2",       I_NONE,        3'd1, O_LOW);
      add(1, "down_lim2",    I_DL,          3'd1, O_CLS);
      add(1, "clear_a2",     I_CA,          3'd0, O_HOLD);
      add(1, "hold2",        I_NONE,        3'd0, O_HOLD);
      add(1, "pair_arrive",  I_AA | I_AB,   3'd2, O_CLS);
      add(1, "clr_a_arr_b",  I_CA | I_AB,   3'd2, O_CLS);
      add(1, "clear_b1",     I_CB,          3'd1, O_CLS);
      add(1, "clear_b2",     I_CB,          3'd0, O_HOLD);
      add(3, "hold3",        I_NONE,        3'd0, O_HOLD);
      add(1, "raise3",       I_NONE,        3'd0, O_RAIS);
      add(1, "reverse",      I_AB,          3'd1, O_LOW);
      add(1, "clear_in_low", I_CB,          3'd0, O_LOW);
      add(1, "underflow",    I_CB,          3'd0, O_LOW);
      add(1, "both_lims_dn", I_DL | I_UL,   3'd0, O_CLS);
      add(1, "closed_empty", I_NONE,        3'd0, O_HOLD);
      add(3, "hold4",        I_NONE,        3'd0, O_HOLD);
      add(1, "raise4",       I_NONE,        3'd0, O_RAIS);
      add(1, "both_lims_up", I_DL | I_UL,   3'd0, O_IDLE);

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // Lowering timeout into FAULT, acknowledge gated by occupancy.
      step(1,  "f_arrive",    I_AA,          3'd1, O_WARN);
      step(7,  "f_warn",      I_NONE,        3'd1, O_WARN);
      step(1,  "f_lower",     I_NONE,        3'd1, O_LOW);
      step(15, "f_lowering",  I_NONE,        3'd1, O_LOW);
      step(1,  "f_timeout",   I_NONE,        3'd1, O_FLT);
      step(1,  "f_clr_busy",  I_FC,          3'd1, O_FLT);
      step(1,  "f_clear",     I_CA,          3'd0, O_FLT);
      step(1,  "f_clr_ok",    I_FC,          3'd0, O_RAIS);

      // Raising timeout, then reset out of FAULT.
      step(15, "r_wait",      I_NONE,        3'd0, O_RAIS);
      step(1,  "r_timeout",   I_NONE,        3'd0, O_FLT);
      step(1,  "rst_fault",   I_RST | I_FC | I_AA, 3'd0, O_IDLE);

      // Limit switch arriving on the final lowering cycle still closes.
      step(1,  "l_arrive",    I_AA,          3'd1, O_WARN);
      step(7,  "l_warn",      I_NONE,        3'd1, O_WARN);
      step(1,  "l_lower",     I_NONE,        3'd1, O_LOW);
      step(15, "l_lowering",  I_NONE,        3'd1, O_LOW);
      step(1,  "l_last_lim",  I_DL,          3'd1, O_CLS);

      // Occupancy saturation at 7.
      step(1,  "sat_3",       I_AA | I_AB,   3'd3, O_CLS);
      step(1,  "sat_5",       I_AA | I_AB,   3'd5, O_CLS);
      step(1,  "sat_7",       I_AA | I_AB,   3'd7, O_CLS);
      step(1,  "sat_hold",    I_AA | I_AB,   3'd7, O_CLS);
      step(1,  "sat_single",  I_AA,          3'd7, O_CLS);
      step(1,  "sat_net0",    I_AA | I_CB,   3'd7, O_CLS);
      step(1,  "sat_dec2",    I_CA | I_CB,   3'd5, O_CLS);

      // Reset while lowering overrides every other input.
      step(1,  "rst2",        I_RST,         3'd0, O_IDLE);
      step(1,  "x_arrive",    I_AB,          3'd1, O_WARN);
      step(7,  "x_warn",      I_NONE,        3'd1, O_WARN);
      step(1,  "x_lower",     I_NONE,        3'd1, O_LOW);
      step(2,  "x_lowering",  I_NONE,        3'd1, O_LOW);
      step(1,  "rst_lowering", I_RST | I_AA | I_DL, 3'd0, O_IDLE);
      step(1,  "after_rst",   I_NONE,        3'd0, O_IDLE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/train_crossing_sequencer.md
TRAIN_CROSSING_SEQUENCER -- requirements
Module: train_crossing_sequencer

Interface
REQ-001 Parameter WARN_CYCLES, default 8, lights+bell pre-warning length before lowering, in cycles (>=1).
REQ-002 Parameter MOTION_TIMEOUT, default 16, maximum cycles allowed for gate travel (>=1).
REQ-003 Parameter HOLD_CYCLES, default 4, cycles of empty occupancy before raising (>=1).
REQ-004 Parameter OCC_W, default 3, width of the train occupancy counter.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 approach_a, approach_b  input  1 each  one-cycle arrival pulses, track A/B (pre-synchronized); each high cycle is one event.
REQ-008 clear_a, clear_b  input  1 each  one-cycle departure pulses, track A/B.
REQ-009 gate_down_lim, gate_up_lim  input  1 each  gate limit switches, levels.
REQ-010 fault_clr  input  1  operator fault acknowledge.
REQ-011 lights  output  1  flashing-light enable.
REQ-012 bell  output  1  bell enable.
REQ-013 gate_cmd_down, gate_cmd_up  output  1 each  motor commands.
REQ-014 fault  output  1  sequencer in FAULT.
REQ-015 occ  output  OCC_W  registered count of trains between approach and clear sensors.

Function
REQ-016 arrivals = approach_a+approach_b, departures = clear_a+clear_b (0..2 each); occ_next = occ + arrivals - departures, clamped to [0, 2^OCC_W-1]; occ <= occ_next every cycle.
REQ-017 Simultaneous arrival and departure on the same cycle: net value applies (A arrival + B clear leaves occ unchanged).
REQ-018 Departure with occ=0: no underflow, occ stays 0; arrival at max: occ stays at max.
REQ-019 States: IDLE, WARN, LOWERING, CLOSED, HOLD, RAISING, FAULT; all transition conditions on occupancy use occ_next.
REQ-020 A single down-counter timer is loaded on state entry; WARN, HOLD last exactly WARN_CYCLES, HOLD_CYCLES cycles; LOWERING/RAISING time out after exactly MOTION_TIMEOUT cycles in state.
REQ-021 IDLE: occ_next>0 -> WARN on next edge.
REQ-022 WARN: timer expiry -> LOWERING; occupancy ignored.
REQ-023 LOWERING: gate_down_lim -> CLOSED; timeout without limit -> FAULT; limit on the last timeout cycle wins (CLOSED).
REQ-024 CLOSED: occ_next=0 -> HOLD.
REQ-025 HOLD: occ_next>0 -> CLOSED; else timer expiry -> RAISING.
REQ-026 RAISING: occ_next>0 -> LOWERING (timer reloaded, priority over limit); else gate_up_lim -> IDLE; else timeout -> FAULT.
REQ-027 FAULT: stays until rst, or fault_clr=1 with occ_next=0 -> RAISING (timer reloaded).
REQ-028 Outputs (Moore, registered state): lights=1 in every state except IDLE; bell=1 in WARN, LOWERING, FAULT; gate_cmd_down=1 in LOWERING, FAULT; gate_cmd_up=1 in RAISING; fault=1 in FAULT only.
REQ-029 gate_cmd_down and gate_cmd_up shall never be high in the same cycle.
REQ-030 Both limit switches high simultaneously: treated per current state rule only; no extra action.

Reset
REQ-031 On rst=1 at a clock edge: state IDLE, timer 0, occ 0, all outputs 0; rst overrides all inputs, including mid-lowering or mid-fault.

Verification
REQ-032 Defaults; approach_a pulse cycle 0 -> cycle 1 occ=1, WARN, lights=bell=1; cycles 1-8 WARN; cycle 9 gate_cmd_down=1; gate_down_lim at cycle 12 -> cycle 13 CLOSED, bell=0, gate_cmd_down=0.
REQ-033 From CLOSED, occ=1, clear_a pulse -> HOLD 4 cycles then RAISING gate_cmd_up=1; gate_up_lim -> IDLE, all outputs 0.
REQ-034 From CLOSED, approach_a and approach_b same cycle -> occ=2; clear_a and approach_b same cycle -> occ stays 2; clear_b twice -> occ=0, HOLD.
REQ-035 LOWERING with no gate_down_lim for 16 cycles -> FAULT, fault=bell=gate_cmd_down=1; fault_clr with occ=1 -> stays FAULT; clear then fault_clr -> RAISING.
REQ-036 RAISING, approach_b pulse -> next cycle LOWERING, gate_cmd_up=0, gate_cmd_down=1; clear_b with occ=0 -> occ stays 0.
REQ-037 rst asserted during LOWERING -> next cycle IDLE, occ=0, all outputs 0.
